// File: rtl/serial_bit_source_if.sv
// Handshake and serial-output bundle for serial_bit_source.
//   master : word producer side (drives data_in/load, observes the serial stream)
//   slave  : serializer side (accepts words, drives ready/w/bit_strobe/busy/done)
//   data_in    word to serialize, sampled on an accepted load
//   load       request to accept data_in
//   ready      serializer can accept a word this cycle
//   w          serial bit stream
//   bit_strobe one-cycle pulse on the last cycle of each bit period
//   busy       word is being shifted out
//   done       one-cycle pulse after the last bit period
interface serial_bit_source_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             w;
    logic             bit_strobe;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load,
        input  ready, w, bit_strobe, busy, done
    );

    modport slave (
        input  data_in, load,
        output ready, w, bit_strobe, busy, done
    );
endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end for the serial sequence-detector FSMs.
// Accepts a WIDTH-bit word on a load/ready handshake and presents it one bit
// at a time on w, each bit held for DIV clocks, with bit_strobe marking the
// last cycle of every bit period.
//   Clock  system clock, rising edge
//   Reset  synchronous, active-high reset
//   bus    serial_bit_source_if slave modport (data_in, load, ready, w,
//          bit_strobe, busy, done)
//
// state | meaning
// IDLE  | waiting for load, ready=1, line idles low
// SHIFT | word being serialized, one bit per DIV clocks
// DONE  | one-cycle completion pulse, then back to IDLE
module serial_bit_source #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               Clock,
    input  logic               Reset,
    serial_bit_source_if.slave bus
);
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BCW-1:0]   bit_cnt, bit_cnt_n;
    logic [DCW-1:0]   div_cnt, div_cnt_n;
    logic             ready_n, w_n, strobe_n, busy_n, done_n;

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;

        case (state)
            IDLE: begin
                // ready is 1 throughout IDLE, so a load here is always accepted
                if (bus.load) begin
                    state_n   = SHIFT;
                    shreg_n   = bus.data_in;
                    bit_cnt_n = '0;
                    div_cnt_n = '0;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    shreg_n   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg[WIDTH-1:1]};
                    // last bit: clear rather than increment so bit_cnt never
                    // holds WIDTH
                    if (bit_cnt == BIT_LAST) begin
                        state_n   = DONE;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                shreg_n   = '0;
                bit_cnt_n = '0;
                div_cnt_n = '0;
            end
        endcase

        // outputs are registered from the next-state values so they line up
        // with the state they describe
        ready_n  = (state_n == IDLE);
        busy_n   = (state_n == SHIFT);
        done_n   = (state_n == DONE);
        w_n      = (state_n == SHIFT) &&
                   (MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0]);
        strobe_n = (state_n == SHIFT) && (div_cnt_n == DIV_LAST);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            div_cnt        <= '0;
            bus.ready      <= 1'b1;
            bus.w          <= 1'b0;
            bus.bit_strobe <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state          <= state_n;
            shreg          <= shreg_n;
            bit_cnt        <= bit_cnt_n;
            div_cnt        <= div_cnt_n;
            bus.ready      <= ready_n;
            bus.w          <= w_n;
            bus.bit_strobe <= strobe_n;
            bus.busy       <= busy_n;
            bus.done       <= done_n;
        end
    end
endmodule
